// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file and its scoreboard.
// Privilege encodings and default geometry used by regfile_scoreboard.
package rf_pkg;

    localparam logic PRIV_USER  = 1'b0;
    localparam logic PRIV_SUPER = 1'b1;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Ports: clk, reset (sync, active-high); set_en/set_addr mark a register
// busy on issue; clr_en/clr_addr clear it on writeback; busy is the full
// bit vector for lookup by the read ports.
import rf_pkg::*;

module rf_scoreboard #(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  logic [ADDR_W-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_nxt;

    // Set is applied after clear so that a same-index issue/writeback pair
    // leaves the bit set: the newly issued writer is still outstanding.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_addr] = 1'b0;
        if (set_en) busy_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with NUM_RD combinational read ports, one writeback
// port with optional write-to-read bypass, a pending-write scoreboard and the
// exception special registers rm0 (pc), rm1 (addr) and rm4 (priv).
// Ports: clk, reset; rd_addr/rd_data/rd_busy (packed per port);
// wr_en/wr_addr/wr_data; issue_en/issue_addr; exc_valid/exc_pc/exc_addr;
// eret; rm0_pc, rm1_addr, priv.
import rf_pkg::*;

module regfile_scoreboard #(
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int NUM_RD   = 3,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     exc_valid,
    input  logic [DATA_W-1:0]        exc_pc,
    input  logic [DATA_W-1:0]        exc_addr,
    input  logic                     eret,
    output logic [DATA_W-1:0]        rm0_pc,
    output logic [DATA_W-1:0]        rm1_addr,
    output logic                     priv
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_ok;
    logic                iss_ok;

    // With a hardwired r0, writes and issues targeting it are dropped so
    // neither the array nor the scoreboard ever records r0 state.
    assign wr_ok  = wr_en &&
                    !((ZERO_REG != 0) && (wr_addr == '0));
    assign iss_ok = issue_en &&
                    !((ZERO_REG != 0) && (issue_addr == '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[wr_addr] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (iss_ok),
        .set_addr (issue_addr),
        .clr_en   (wr_ok),
        .clr_addr (wr_addr),
        .busy     (busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              is_zero;
        logic              wr_hit;
        logic              iss_hit;

        assign ra      = rd_addr[k*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);
        assign wr_hit  = (BYPASS != 0) && wr_ok && (wr_addr == ra);
        assign iss_hit = iss_ok && (issue_addr == ra);

        // A forwarded write retires the pending entry for this reader,
        // unless a new writer to the same register issues this cycle.
        always_comb begin
            rd_data[k*DATA_W +: DATA_W] = regs[ra];
            rd_busy[k]                  = busy[ra];
            if (is_zero) begin
                rd_data[k*DATA_W +: DATA_W] = '0;
                rd_busy[k]                  = 1'b0;
            end else if (wr_hit) begin
                rd_data[k*DATA_W +: DATA_W] = wr_data;
                rd_busy[k]                  = iss_hit;
            end
        end
    end

    // Exception entry outranks a simultaneous eret.
    always_ff @(posedge clk) begin
        if (reset) begin
            rm0_pc   <= '0;
            rm1_addr <= '0;
            priv     <= PRIV_SUPER;
        end else if (exc_valid) begin
            rm0_pc   <= exc_pc;
            rm1_addr <= exc_addr;
            priv     <= PRIV_SUPER;
        end else if (eret) begin
            priv     <= PRIV_USER;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: one instance with bypass, one
// without, driven by the same stimulus and checked against fixed values.
module tb_regfile_scoreboard;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data_a, rd_data_b;
    logic [NR-1:0]    rd_busy_a, rd_busy_b;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             issue_en;
    logic [AW-1:0]    issue_addr;
    logic             exc_valid;
    logic [DW-1:0]    exc_pc, exc_addr;
    logic             eret;
    logic [DW-1:0]    rm0_a, rm1_a, rm0_b, rm1_b;
    logic             priv_a, priv_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .exc_valid(exc_valid), .exc_pc(exc_pc),
        .exc_addr(exc_addr), .eret(eret),
        .rm0_pc(rm0_a), .rm1_addr(rm1_a), .priv(priv_a)
    );

    regfile_scoreboard #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .exc_valid(exc_valid), .exc_pc(exc_pc),
        .exc_addr(exc_addr), .eret(eret),
        .rm0_pc(rm0_b), .rm1_addr(rm1_b), .priv(priv_b)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change at #1 after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        issue_en  = 1'b0;
        exc_valid = 1'b0;
        eret      = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    initial begin
        rd_addr    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        issue_addr = '0;
        exc_pc     = '0;
        exc_addr   = '0;
        idle();

        // 1: reset state
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        for (int a = 0; a < 32; a++) begin
            set_rd(0, AW'(a));
            set_rd(1, AW'((a + 1) % 32));
            set_rd(2, AW'((a + 2) % 32));
            #1;
            check("rst_data_a", 64'(rd_data_a), 64'd0);
            check("rst_data_b", 64'(rd_data_b), 64'd0);
            check("rst_busy_a", 64'(rd_busy_a), 64'd0);
            check("rst_busy_b", 64'(rd_busy_b), 64'd0);
        end
        check("rst_priv", 64'(priv_a), 64'd1);
        check("rst_rm0", 64'(rm0_a), 64'd0);
        check("rst_rm1", 64'(rm1_a), 64'd0);

        // 2: bypass vs stored read
        tick();
        set_rd(0, 5);
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        #1;
        check("byp_same_a", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
        check("byp_same_b", 64'(rd_data_b[31:0]), 64'h0);
        tick();
        idle();
        #1;
        check("byp_next_a", 64'(rd_data_a[31:0]), 64'hDEADBEEF);
        check("byp_next_b", 64'(rd_data_b[31:0]), 64'hDEADBEEF);

        // 3: r0 hardwired
        set_rd(0, 0);
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234;
        issue_en = 1'b1; issue_addr = 0;
        #1;
        check("r0_byp_data", 64'(rd_data_a[31:0]), 64'h0);
        check("r0_byp_busy", 64'(rd_busy_a[0]), 64'd0);
        tick();
        idle();
        #1;
        check("r0_data_a", 64'(rd_data_a[31:0]), 64'h0);
        check("r0_data_b", 64'(rd_data_b[31:0]), 64'h0);
        check("r0_busy_b", 64'(rd_busy_b[0]), 64'd0);

        // 4: scoreboard on r7
        issue_en = 1'b1; issue_addr = 7;
        tick();
        idle();
        set_rd(1, 7);
        #1;
        check("r7_busy_a", 64'(rd_busy_a[1]), 64'd1);
        check("r7_busy_b", 64'(rd_busy_b[1]), 64'd1);
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h55;
        issue_en = 1'b1; issue_addr = 7;
        #1;
        check("r7_wi_data_a", 64'(rd_data_a[63:32]), 64'h55);
        check("r7_wi_busy_a", 64'(rd_busy_a[1]), 64'd1);
        check("r7_wi_data_b", 64'(rd_data_b[63:32]), 64'h0);
        tick();
        idle();
        #1;
        check("r7_after_a", 64'(rd_data_a[63:32]), 64'h55);
        check("r7_after_b", 64'(rd_data_b[63:32]), 64'h55);
        check("r7_still_a", 64'(rd_busy_a[1]), 64'd1);
        check("r7_still_b", 64'(rd_busy_b[1]), 64'd1);
        // lone write to r7 alongside an issue to another register
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'h66;
        issue_en = 1'b1; issue_addr = 9;
        set_rd(2, 9);
        #1;
        check("r7_lone_byp_a", 64'(rd_busy_a[1]), 64'd0);
        check("r7_lone_byp_b", 64'(rd_busy_b[1]), 64'd1);
        tick();
        idle();
        #1;
        check("r7_clr_a", 64'(rd_busy_a[1]), 64'd0);
        check("r7_clr_b", 64'(rd_busy_b[1]), 64'd0);
        check("r7_data", 64'(rd_data_b[63:32]), 64'h66);
        check("r9_busy", 64'(rd_busy_a[2]), 64'd1);

        // 5: exception and eret
        exc_valid = 1'b1; exc_pc = 32'h100; exc_addr = 32'h2004;
        eret = 1'b1;
        tick();
        idle();
        #1;
        check("exc_rm0", 64'(rm0_a), 64'h100);
        check("exc_rm1", 64'(rm1_a), 64'h2004);
        check("exc_priv", 64'(priv_a), 64'd1);
        eret = 1'b1;
        exc_pc = 32'hBAD; exc_addr = 32'hBAD;
        tick();
        idle();
        #1;
        check("eret_priv", 64'(priv_a), 64'd0);
        check("eret_rm0", 64'(rm0_a), 64'h100);
        check("eret_rm1", 64'(rm1_b), 64'h2004);

        // 6: reset dominates write and issue
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'hFF;
        issue_en = 1'b1; issue_addr = 3;
        tick();
        idle();
        set_rd(2, 3);
        set_rd(0, 5);
        #1;
        check("rst2_r3_data", 64'(rd_data_a[95:64]), 64'h0);
        check("rst2_r3_busy", 64'(rd_busy_a[2]), 64'd0);
        check("rst2_r3_busy_b", 64'(rd_busy_b[2]), 64'd0);
        check("rst2_r5_data", 64'(rd_data_b[31:0]), 64'h0);
        check("rst2_priv", 64'(priv_a), 64'd1);
        check("rst2_rm0", 64'(rm0_a), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
